// File: rtl/tx_pkg.sv
// Shared mode encodings, symbol counts and the holding-register layout for the Tx serializer.
// Pure declarations; no timing or backpressure of its own.
package tx_pkg;

  localparam logic [3:0] MODE_BPSK = 4'b0001;
  localparam logic [3:0] MODE_QPSK = 4'b0010;
  localparam logic [3:0] MODE_MIX  = 4'b0100;

  localparam int BPSK_SYMS = 8;
  localparam int QPSK_SYMS = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } hold_t;

  // Anything that is not a clean one-hot QPSK/MIX code falls back to BPSK.
  function automatic logic use_qpsk(input logic [3:0] mode, input logic user);
    logic q;
    case (mode)
      MODE_QPSK: q = 1'b1;
      MODE_MIX:  q = !user;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/tx_byte_hold.sv
// One-entry byte holding register; capture on valid&ready, released by i_pop.
// Ready is registered (!full) and drops the cycle after a capture.
module tx_byte_hold
  import tx_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_vld,
  input  hold_t i_dat,
  input  logic  i_pop,
  output logic  o_rdy,
  output logic  o_full,
  output hold_t o_dat
);

  logic  r_full;
  logic  r_rdy;
  hold_t r_dat;
  logic  w_push;
  logic  w_pop;
  logic  w_full_nxt;

  assign w_push     = i_vld & r_rdy;
  assign w_pop      = i_pop & r_full;
  assign w_full_nxt = w_push | (r_full & ~w_pop);

  // Ready stays low throughout reset and rises on the first clock after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_rdy  <= 1'b0;
      r_dat  <= '0;
    end else begin
      r_full <= w_full_nxt;
      r_rdy  <= ~w_full_nxt;
      if (w_push) r_dat <= i_dat;
    end
  end

  assign o_rdy  = r_rdy;
  assign o_full = r_full;
  assign o_dat  = r_dat;

endmodule

// File: rtl/tx_symbol_serializer.sv
// Byte-to-symbol serializer (BPSK/QPSK/MIX); symbols update on the clock after sym_tick.
// Backpressure via registered s_tready from the one-entry hold; an empty hold at a tick yields an idle symbol.
module tx_symbol_serializer
  import tx_pkg::*;
#(
  parameter int UNDERRUN_W = 16
) (
  input  logic                  clk_16M384,
  input  logic                  rst_16M384,
  input  logic [3:0]            MODE_CTRL,
  input  logic                  sym_tick,
  input  logic [7:0]            s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic                  s_tuser,
  output logic [1:0]            sym_bits,
  output logic                  sym_vld,
  output logic                  sym_qpsk,
  output logic                  sym_last,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  hold_t w_in;
  hold_t w_hold;
  logic  w_hold_full;
  logic  w_rem_le1;
  logic  w_load;
  logic  w_shift;
  logic  w_idle;
  logic  w_load_qpsk;

  logic [7:0]            r_sh;
  logic [3:0]            r_rem;
  logic                  r_qpsk;
  logic                  r_byte_last;
  logic                  r_in_frame;
  logic [1:0]            r_bits;
  logic                  r_vld;
  logic                  r_sym_qpsk;
  logic                  r_sym_last;
  logic [UNDERRUN_W-1:0] r_underrun;

  assign w_in = '{data: s_tdata, last: s_tlast, user: s_tuser};

  tx_byte_hold u_hold (
    .clk    (clk_16M384),
    .rst    (rst_16M384),
    .i_vld  (s_tvalid),
    .i_dat  (w_in),
    .i_pop  (w_load),
    .o_rdy  (s_tready),
    .o_full (w_hold_full),
    .o_dat  (w_hold)
  );

  assign w_rem_le1   = (r_rem <= 4'd1);
  assign w_shift     = sym_tick & ~w_rem_le1;
  assign w_load      = sym_tick & w_rem_le1 & w_hold_full;
  assign w_idle      = sym_tick & w_rem_le1 & ~w_hold_full;
  assign w_load_qpsk = use_qpsk(MODE_CTRL, w_hold.user);

  // r_rem counts the symbols of the current byte still to be shown, including the one on the outputs.
  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      r_sh        <= '0;
      r_rem       <= '0;
      r_qpsk      <= 1'b0;
      r_byte_last <= 1'b0;
      r_in_frame  <= 1'b0;
      r_bits      <= 2'b00;
      r_vld       <= 1'b0;
      r_sym_qpsk  <= 1'b0;
      r_sym_last  <= 1'b0;
      r_underrun  <= '0;
    end else if (w_shift) begin
      if (r_qpsk) begin
        r_bits <= r_sh[7:6];
        r_sh   <= r_sh << 2;
      end else begin
        r_bits <= {r_sh[7], 1'b0};
        r_sh   <= r_sh << 1;
      end
      r_rem      <= r_rem - 4'd1;
      r_vld      <= 1'b1;
      r_sym_qpsk <= r_qpsk;
      r_sym_last <= r_byte_last && (r_rem == 4'd2);
      if (r_byte_last && (r_rem == 4'd2)) r_in_frame <= 1'b0;
    end else if (w_load) begin
      r_qpsk      <= w_load_qpsk;
      r_byte_last <= w_hold.last;
      if (w_load_qpsk) begin
        r_bits <= w_hold.data[7:6];
        r_sh   <= w_hold.data << 2;
        r_rem  <= 4'(QPSK_SYMS);
      end else begin
        r_bits <= {w_hold.data[7], 1'b0};
        r_sh   <= w_hold.data << 1;
        r_rem  <= 4'(BPSK_SYMS);
      end
      r_vld      <= 1'b1;
      r_sym_qpsk <= w_load_qpsk;
      r_sym_last <= 1'b0;
      r_in_frame <= 1'b1;
    end else if (w_idle) begin
      r_rem      <= '0;
      r_bits     <= 2'b00;
      r_vld      <= 1'b0;
      r_sym_qpsk <= 1'b0;
      r_sym_last <= 1'b0;
      if (r_in_frame && (r_underrun != '1)) r_underrun <= r_underrun + 1'b1;
    end
  end

  assign sym_bits     = r_bits;
  assign sym_vld      = r_vld;
  assign sym_qpsk     = r_sym_qpsk;
  assign sym_last     = r_sym_last;
  assign underrun_cnt = r_underrun;

endmodule

// File: tb/tb_tx_symbol_serializer.sv
// Scoreboard bench for tx_symbol_serializer: stimulus pushes expected symbols, a monitor pops on every tick.
module tb_tx_symbol_serializer;

  logic        clk;
  logic        rst;
  logic [3:0]  mode;
  logic        sym_tick;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic        s_tuser;
  logic [1:0]  sym_bits;
  logic        sym_vld;
  logic        sym_qpsk;
  logic        sym_last;
  logic [15:0] underrun_cnt;

  typedef struct packed {
    logic [1:0] bits;
    logic       qpsk;
    logic       last;
  } sym_t;

  sym_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   tick_seen = 0;
  int   gap_cnt = 0;
  bit   mid_frame = 0;
  bit   tick_en = 0;
  int   tick_period = 128;

  tx_symbol_serializer #(.UNDERRUN_W(16)) dut (
    .clk_16M384   (clk),
    .rst_16M384   (rst),
    .MODE_CTRL    (mode),
    .sym_tick     (sym_tick),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .s_tuser      (s_tuser),
    .sym_bits     (sym_bits),
    .sym_vld      (sym_vld),
    .sym_qpsk     (sym_qpsk),
    .sym_last     (sym_last),
    .underrun_cnt (underrun_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  initial begin : tickgen
    int cnt;
    cnt = 0;
    sym_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en && cnt == tick_period - 1) begin
        sym_tick = 1'b1;
        cnt = 0;
      end else begin
        sym_tick = 1'b0;
        if (tick_en) cnt++;
        else cnt = 0;
      end
    end
  end

  initial begin : monitor
    sym_t a;
    sym_t e;
    logic t;
    forever begin
      @(posedge clk);
      t = sym_tick && !rst;
      @(negedge clk);
      if (t && !rst) begin
        tick_seen++;
        if (sym_vld) begin
          a = '{bits: sym_bits, qpsk: sym_qpsk, last: sym_last};
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_symbol: got %b required none", a);
          end else begin
            e = exp_q.pop_front();
            check("symbol{bits,qpsk,last}", 32'(a), 32'(e));
          end
          mid_frame = !sym_last;
        end else begin
          check("idle_bits_last", {29'd0, sym_bits, sym_last}, 32'd0);
          if (mid_frame) gap_cnt++;
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    int target;
    target = tick_seen + n;
    for (int i = 0; i < (n + 4) * tick_period && tick_seen < target; i++) @(negedge clk);
    if (tick_seen < target) begin
      total++;
      bad++;
      $display("FAIL wait_ticks: got %0d ticks required %0d", tick_seen, target);
    end
  endtask

  task automatic wait_qsize(input int n);
    for (int i = 0; i < 24 * tick_period && exp_q.size() > n; i++) @(negedge clk);
    if (exp_q.size() > n) begin
      total++;
      bad++;
      $display("FAIL wait_queue: got %0d pending required %0d", exp_q.size(), n);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic u, input logic q);
    int n;
    int w;
    sym_t s;
    n = q ? 4 : 8;
    for (int k = 0; k < n; k++) begin
      s.bits = q ? d[7-2*k -: 2] : {d[7-k], 1'b0};
      s.qpsk = q;
      s.last = l && (k == n - 1);
      exp_q.push_back(s);
    end
    w = 0;
    while (!s_tready && w < 24 * tick_period) begin
      @(negedge clk);
      w++;
    end
    if (!s_tready) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: got s_tready=0 required 1");
    end
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    mode     = 4'b0001;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    #1;
    check("reset_sym_bits", 32'(sym_bits), 32'd0);
    check("reset_sym_vld", 32'(sym_vld), 32'd0);
    check("reset_sym_qpsk", 32'(sym_qpsk), 32'd0);
    check("reset_sym_last", 32'(sym_last), 32'd0);
    check("reset_underrun", 32'(underrun_cnt), 32'd0);
    repeat (3) @(negedge clk);
    check("reset_tready_low", 32'(s_tready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_release", 32'(s_tready), 32'd1);
    tick_en = 1'b1;

    // 1: BPSK single byte with tlast
    mode = 4'b0001;
    send_byte(8'hA5, 1'b1, 1'b0, 1'b0);
    wait_qsize(0);
    wait_ticks(1);
    check("t1_gaps", 32'(gap_cnt), 32'd0);

    // 2: QPSK back-to-back bytes, no idle in between
    mode = 4'b0010;
    send_byte(8'h1B, 1'b0, 1'b0, 1'b1);
    send_byte(8'hE4, 1'b1, 1'b0, 1'b1);
    wait_qsize(0);
    check("t2_gaps", 32'(gap_cnt), 32'd0);

    // 3: MIX header as BPSK, payload as QPSK
    mode = 4'b0100;
    send_byte(8'hF0, 1'b0, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0, 1'b1);
    wait_qsize(0);
    check("t3_gaps", 32'(gap_cnt), 32'd0);
    check("t3_underrun", 32'(underrun_cnt), 32'd0);

    // 4: second byte of a frame arrives three ticks late
    mode = 4'b0001;
    send_byte(8'h81, 1'b0, 1'b0, 1'b0);
    wait_qsize(0);
    wait_ticks(3);
    send_byte(8'h7E, 1'b1, 1'b0, 1'b0);
    wait_qsize(0);
    check("t4_underrun", 32'(underrun_cnt), 32'd3);
    check("t4_gaps", 32'(gap_cnt), 32'd3);
    wait_ticks(3);
    check("t4_underrun_after_tlast", 32'(underrun_cnt), 32'd3);

    // 5: mode changes mid-byte; invalid code behaves as BPSK for the next byte
    mode = 4'b0010;
    send_byte(8'hC6, 1'b0, 1'b0, 1'b1);
    send_byte(8'h39, 1'b1, 1'b0, 1'b0);
    wait_qsize(10);
    mode = 4'b0011;
    wait_qsize(0);
    check("t5_gaps", 32'(gap_cnt), 32'd3);
    check("t5_underrun", 32'(underrun_cnt), 32'd3);

    // 6: reset in the middle of a byte
    mode = 4'b0001;
    send_byte(8'h96, 1'b1, 1'b0, 1'b0);
    wait_qsize(5);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_sym_bits", 32'(sym_bits), 32'd0);
    check("t6_rst_sym_vld", 32'(sym_vld), 32'd0);
    check("t6_rst_sym_last", 32'(sym_last), 32'd0);
    check("t6_rst_sym_qpsk", 32'(sym_qpsk), 32'd0);
    check("t6_rst_underrun", 32'(underrun_cnt), 32'd0);
    check("t6_rst_tready", 32'(s_tready), 32'd0);
    exp_q.delete();
    mid_frame = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_tready_after_release", 32'(s_tready), 32'd1);
    check("t6_underrun_after_release", 32'(underrun_cnt), 32'd0);
    send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
    wait_qsize(0);
    wait_ticks(2);
    check("t6_underrun_end", 32'(underrun_cnt), 32'd0);
    check("t6_gaps", 32'(gap_cnt), 32'd3);
    check("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
